// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller:
// state encoding, opcode/funct values, datapath select codes, instruction classes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_XOR   = 6'h26;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] A3_RD    = 2'b00;
    localparam logic [1:0] A3_RT    = 2'b01;
    localparam logic [1:0] A3_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    // Exactly one flag is set for any instruction word.
    typedef struct packed {
        logic rtype;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic jr;
        logic nop;
    } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: one-hot instruction class plus the
// EXEC-stage ALU controls. Unrecognised encodings decode as nop.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output instr_cls_t  cls,
    output logic [2:0]  alu_op,
    output logic        alu_b_sel,
    output logic        ext_sign
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls       = '0;
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        ext_sign  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin cls.rtype = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin cls.rtype = 1'b1; alu_op = ALU_SUB; end
                    FN_XOR: begin cls.rtype = 1'b1; alu_op = ALU_XOR; end
                    FN_JR:  cls.jr  = 1'b1;
                    default: cls.nop = 1'b1;
                endcase
            end
            OP_ORI: begin cls.ori = 1'b1; alu_op = ALU_OR;  alu_b_sel = 1'b1; end
            OP_LUI: begin cls.lui = 1'b1; alu_op = ALU_LUI; alu_b_sel = 1'b1; end
            OP_LW:  begin cls.lw  = 1'b1; alu_b_sel = 1'b1; ext_sign = 1'b1; end
            OP_SW:  begin cls.sw  = 1'b1; alu_b_sel = 1'b1; ext_sign = 1'b1; end
            OP_BEQ: begin cls.beq = 1'b1; alu_op = ALU_SUB; end
            OP_JAL: cls.jal = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        grf_we,
    output logic [1:0]  a3_sel,
    output logic [1:0]  wd_sel,
    output logic        alu_b_sel,
    output logic        ext_sign,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic        retire,
    output logic        fault
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t            cur_state;
    state_t            nxt_state;
    instr_cls_t        cls;
    logic [2:0]        dec_alu_op;
    logic              dec_alu_b_sel;
    logic              dec_ext_sign;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_access;
    logic              timeout_hit;

    mc_decode u_decode (
        .instr     (instr),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .alu_b_sel (dec_alu_b_sel),
        .ext_sign  (dec_ext_sign)
    );

    assign state     = cur_state;
    assign in_access = (cur_state == ST_FETCH) || (cur_state == ST_MEM);
    // A ready in the final allowed cycle completes the access instead of faulting.
    assign timeout_hit = (MEM_TIMEOUT != 0) && in_access && !mem_ready &&
                         (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= ST_IDLE;
            fault     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state == ST_FAULT)
                fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if ((nxt_state != cur_state) &&
                 ((nxt_state == ST_FETCH) || (nxt_state == ST_MEM)))
            wait_cnt <= '0;
        else if (in_access && !mem_ready)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE:   nxt_state = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)        nxt_state = ST_DECODE;
                else if (timeout_hit) nxt_state = ST_FAULT;
            end
            ST_DECODE: begin
                if (cls.jal || cls.jr || cls.nop) nxt_state = ST_FETCH;
                else                              nxt_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (cls.beq)                           nxt_state = ST_FETCH;
                else if (cls.lw || cls.sw)             nxt_state = ST_MEM;
                else if (cls.rtype || cls.ori || cls.lui) nxt_state = ST_WB;
                else                                   nxt_state = ST_FETCH;
            end
            ST_MEM: begin
                if (mem_ready)        nxt_state = cls.sw ? ST_FETCH : ST_WB;
                else if (timeout_hit) nxt_state = ST_FAULT;
            end
            ST_WB:     nxt_state = ST_FETCH;
            ST_FAULT:  nxt_state = ST_FAULT;
            default:   nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        npc_sel   = NPC_PC4;
        grf_we    = 1'b0;
        a3_sel    = A3_RD;
        wd_sel    = WD_ALU;
        alu_b_sel = 1'b0;
        ext_sign  = 1'b0;
        alu_op    = ALU_ADD;
        retire    = 1'b0;
        // ALU controls stay at their EXEC values until writeback completes.
        if ((cur_state == ST_EXEC) || (cur_state == ST_MEM) || (cur_state == ST_WB)) begin
            alu_op    = dec_alu_op;
            alu_b_sel = dec_alu_b_sel;
            ext_sign  = dec_ext_sign;
        end
        case (cur_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            ST_DECODE: begin
                if (cls.jal) begin
                    grf_we  = 1'b1;
                    a3_sel  = A3_RA;
                    wd_sel  = WD_PC;
                    pc_we   = 1'b1;
                    npc_sel = NPC_JAL;
                    retire  = 1'b1;
                end else if (cls.jr) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_JR;
                    retire  = 1'b1;
                end else if (cls.nop) begin
                    retire  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cls.beq) begin
                    pc_we   = alu_zero;
                    npc_sel = NPC_BR;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = cls.sw;
                retire  = mem_ready && cls.sw;
            end
            ST_WB: begin
                grf_we = 1'b1;
                a3_sel = cls.rtype ? A3_RD : A3_RT;
                wd_sel = cls.lw ? WD_MEM : WD_ALU;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (cur_state != ST_FAULT)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (MEM_TIMEOUT=4, CNT_W=4).
// Counter checks are compiled in when MC_PERF_CNT_EN is defined.
module tb_mc_controller;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_req, mem_we, mem_sel, ir_we, pc_we, grf_we;
    logic [1:0]  npc_sel, a3_sel, wd_sel;
    logic        alu_b_sel, ext_sign, retire, fault;
    logic [2:0]  alu_op, state;
`ifdef MC_PERF_CNT_EN
    logic [3:0]  cycle_cnt, retire_cnt;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    localparam logic [31:0] I_ORI  = 32'h34011234;
    localparam logic [31:0] I_LW   = 32'h8c040004;
    localparam logic [31:0] I_SW   = 32'hac040008;
    localparam logic [31:0] I_BEQ  = 32'h10210001;
    localparam logic [31:0] I_JAL  = 32'h0c000003;
    localparam logic [31:0] I_NOP  = 32'h00000000;
    localparam logic [31:0] I_UNK  = 32'hfc000000;
    localparam logic [31:0] I_JR   = 32'h03e00008;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_LUI  = 32'h3c01abcd;

    mc_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .grf_we    (grf_we),
        .a3_sel    (a3_sel),
        .wd_sel    (wd_sel),
        .alu_b_sel (alu_b_sel),
        .ext_sign  (ext_sign),
        .alu_op    (alu_op),
        .state     (state),
        .retire    (retire),
        .fault     (fault)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, then apply this cycle's inputs and let them settle.
    task automatic cyc(input logic [31:0] i, input logic r, input logic z);
        @(posedge clk);
        #1;
        instr     = i;
        mem_ready = r;
        alu_zero  = z;
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] st,
                       input logic req, input logic we, input logic msel,
                       input logic irwe, input logic pcwe, input logic [1:0] npc,
                       input logic grf, input logic [1:0] a3, input logic [1:0] wd,
                       input logic bsel, input logic ext, input logic [2:0] aop,
                       input logic ret, input logic flt);
        logic [21:0] obs;
        logic [21:0] exp;
        obs = {state, mem_req, mem_we, mem_sel, ir_we, pc_we, npc_sel, grf_we,
               a3_sel, wd_sel, alu_b_sel, ext_sign, alu_op, retire, fault};
        exp = {st, req, we, msel, irwe, pcwe, npc, grf, a3, wd, bsel, ext, aop, ret, flt};
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag);
        chk(tag, 3'd1, 1,0,0, 1,1,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0);
    endtask

    task automatic chk_idle_dec(input string tag, input logic [2:0] st);
        chk(tag, st, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0);
    endtask

    initial begin
        reset_n   = 1'b0;
        instr     = '0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        #2;
        chk_idle_dec("reset", 3'd0);
`ifdef MC_PERF_CNT_EN
        n_asserts++;
        assert ({cycle_cnt, retire_cnt} === 8'h00) else begin
            n_fail++;
            $error("FAIL perf_reset: observed %h expected 00", {cycle_cnt, retire_cnt});
        end
`endif
        #10 reset_n = 1'b1;
        #1 chk_idle_dec("idle", 3'd0);

        // Fetch stalls, then reset mid-access drops mem_req immediately
        cyc(I_NOP, 0, 0);
        chk("fetch_wait1", 3'd1, 1,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0);
        cyc(I_NOP, 0, 0);
        chk("fetch_wait2", 3'd1, 1,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0);
        #2 reset_n = 1'b0;
        #1 chk_idle_dec("reset_mid_fetch", 3'd0);
        #2 reset_n = 1'b1;

        // ori: 1 -> 2 -> 3 -> 5 -> 1
        cyc(I_ORI, 1, 0); chk_fetch("ori_fetch");
        cyc(I_ORI, 1, 0); chk_idle_dec("ori_decode", 3'd2);
        cyc(I_ORI, 1, 0); chk("ori_exec", 3'd3, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 1,0,3'b011, 0,0);
        cyc(I_ORI, 1, 0); chk("ori_wb",   3'd5, 0,0,0, 0,0,2'b00, 1,2'b01,2'b00, 1,0,3'b011, 1,0);

        // lw: ready withheld for 3 MEM cycles, arrives on the last allowed one
        cyc(I_LW, 1, 0); chk_fetch("lw_fetch");
        cyc(I_LW, 1, 0); chk_idle_dec("lw_decode", 3'd2);
        cyc(I_LW, 1, 0); chk("lw_exec", 3'd3, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0);
        for (int k = 0; k < 3; k++) begin
            cyc(I_LW, 0, 0);
            chk("lw_mem_wait", 3'd4, 1,0,1, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0);
        end
        cyc(I_LW, 1, 0); chk("lw_mem_ready", 3'd4, 1,0,1, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0);
        cyc(I_LW, 1, 0); chk("lw_wb", 3'd5, 0,0,0, 0,0,2'b00, 1,2'b01,2'b01, 1,1,3'b000, 1,0);

        // sub (R-type)
        cyc(I_SUB, 1, 0); chk_fetch("sub_fetch");
        cyc(I_SUB, 1, 0); chk_idle_dec("sub_decode", 3'd2);
        cyc(I_SUB, 1, 0); chk("sub_exec", 3'd3, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b001, 0,0);
        cyc(I_SUB, 1, 0); chk("sub_wb",   3'd5, 0,0,0, 0,0,2'b00, 1,2'b00,2'b00, 0,0,3'b001, 1,0);

        // lui
        cyc(I_LUI, 1, 0); chk_fetch("lui_fetch");
        cyc(I_LUI, 1, 0); chk_idle_dec("lui_decode", 3'd2);
        cyc(I_LUI, 1, 0); chk("lui_exec", 3'd3, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 1,0,3'b100, 0,0);
        cyc(I_LUI, 1, 0); chk("lui_wb",   3'd5, 0,0,0, 0,0,2'b00, 1,2'b01,2'b00, 1,0,3'b100, 1,0);

        // beq taken, then not taken; the following fetch confirms 3 cycles each
        cyc(I_BEQ, 1, 0); chk_fetch("beq_t_fetch");
        cyc(I_BEQ, 1, 0); chk_idle_dec("beq_t_decode", 3'd2);
        cyc(I_BEQ, 1, 1); chk("beq_taken", 3'd3, 0,0,0, 0,1,2'b01, 0,2'b00,2'b00, 0,0,3'b001, 1,0);
        cyc(I_BEQ, 1, 0); chk_fetch("beq_nt_fetch");
        cyc(I_BEQ, 1, 0); chk_idle_dec("beq_nt_decode", 3'd2);
        cyc(I_BEQ, 1, 0); chk("beq_not_taken", 3'd3, 0,0,0, 0,0,2'b01, 0,2'b00,2'b00, 0,0,3'b001, 1,0);

        // 2-cycle instructions: jal, nop, unknown, jr
        cyc(I_JAL, 1, 0); chk_fetch("jal_fetch");
        cyc(I_JAL, 1, 0); chk("jal_decode", 3'd2, 0,0,0, 0,1,2'b10, 1,2'b10,2'b10, 0,0,3'b000, 1,0);
        cyc(I_NOP, 1, 0); chk_fetch("nop_fetch");
        cyc(I_NOP, 1, 0); chk("nop_decode", 3'd2, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 1,0);
        cyc(I_UNK, 1, 0); chk_fetch("unk_fetch");
        cyc(I_UNK, 1, 0); chk("unk_decode", 3'd2, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 1,0);
        cyc(I_JR, 1, 0);  chk_fetch("jr_fetch");
        cyc(I_JR, 1, 0);  chk("jr_decode", 3'd2, 0,0,0, 0,1,2'b11, 0,2'b00,2'b00, 0,0,3'b000, 1,0);

        // sw with memory never ready in MEM: FAULT after 4 wait cycles
        cyc(I_SW, 1, 0); chk_fetch("sw_fetch");
        cyc(I_SW, 1, 0); chk_idle_dec("sw_decode", 3'd2);
        cyc(I_SW, 1, 0); chk("sw_exec", 3'd3, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0);
        for (int k = 0; k < 4; k++) begin
            cyc(I_SW, 0, 0);
            chk("sw_mem_wait", 3'd4, 1,1,1, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0);
        end
        cyc(I_SW, 1, 0); chk("fault_enter", 3'd7, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,1);
        cyc(I_SW, 1, 1); chk("fault_hold",  3'd7, 0,0,0, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,1);
        #2 reset_n = 1'b0;
        #1 chk_idle_dec("fault_reset", 3'd0);

`ifdef MC_PERF_CNT_EN
        // 20 counted cycles (IDLE + 19 nop cycles) wrap a 4-bit cycle counter to 4; 9 retires
        #1 reset_n = 1'b1;
        for (int k = 0; k < 20; k++)
            cyc(I_NOP, 1, 0);
        n_asserts++;
        assert ({cycle_cnt, retire_cnt} === {4'd4, 4'd9}) else begin
            n_fail++;
            $error("FAIL perf_wrap: observed %h expected %h", {cycle_cnt, retire_cnt}, {4'd4, 4'd9});
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
